// File: rtl/status_transmitter_if.sv
// Signal bundle between the status source, the serial transmitter and the MBED-facing pins.
// The slave modport is the transmitter's view; master is the view of whoever drives load/word/ack.
interface status_transmitter_if #(
  parameter int WORD_WIDTH = 10
) ();
  logic                  load;
  logic [WORD_WIDTH-1:0] word;
  logic                  tx_ack;
  logic                  tx_ready;
  logic                  tx_bit;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;
  logic [1:0]            tx_state;

  modport master (
    output load, word, tx_ack,
    input  tx_ready, tx_bit, busy, done, timeout_err, tx_state
  );

  modport slave (
    input  load, word, tx_ack,
    output tx_ready, tx_bit, busy, done, timeout_err, tx_state
  );
endinterface

// File: rtl/status_transmitter.sv
// Bit-serial status word transmitter toward the MBED: four-phase ready/ack per bit, MSB first,
// with a per-phase acknowledge timeout so a silent MBED cannot hang the sender.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | no transfer; waits for load
// S_SETUP     | current bit driven on tx_bit, tx_ready low for SETUP_CYCLES
// S_WAIT_HI   | tx_ready high, waiting for synchronized ack to rise
// S_WAIT_LO   | tx_ready low again, waiting for synchronized ack to fall
module status_transmitter #(
  parameter int WORD_WIDTH   = 10,
  parameter int SETUP_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 24000000
) (
  input logic                 clk,
  input logic                 reset,
  status_transmitter_if.slave bus
);

  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int IW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_MSB    = IW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [WORD_WIDTH-1:0] shift, shift_n;
  logic [IW-1:0]         idx, idx_n;
  logic [SW-1:0]         setup_cnt, setup_cnt_n;
  logic [TW-1:0]         tout_cnt, tout_cnt_n;
  logic                  ready_q, ready_n;
  logic                  bit_q, bit_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  terr_q, terr_n;
  logic [1:0]            ack_sync;
  logic                  ack_s;
  logic                  tout_last;

  assign ack_s     = ack_sync[1];
  assign tout_last = (tout_cnt == TOUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_sync  <= '0;
      state     <= S_IDLE;
      shift     <= '0;
      idx       <= '0;
      setup_cnt <= '0;
      tout_cnt  <= '0;
      ready_q   <= 1'b0;
      bit_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      ack_sync  <= {ack_sync[0], bus.tx_ack};
      state     <= state_n;
      shift     <= shift_n;
      idx       <= idx_n;
      setup_cnt <= setup_cnt_n;
      tout_cnt  <= tout_cnt_n;
      ready_q   <= ready_n;
      bit_q     <= bit_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      terr_q    <= terr_n;
    end
  end

  always_comb begin
    state_n     = state;
    shift_n     = shift;
    idx_n       = idx;
    setup_cnt_n = setup_cnt;
    tout_cnt_n  = tout_cnt;
    ready_n     = ready_q;
    bit_n       = bit_q;
    busy_n      = busy_q;
    done_n      = 1'b0;
    terr_n      = 1'b0;

    unique case (state)
      S_IDLE: begin
        ready_n = 1'b0;
        busy_n  = 1'b0;
        if (bus.load) begin
          shift_n     = bus.word;
          idx_n       = IDX_MSB;
          busy_n      = 1'b1;
          bit_n       = bus.word[WORD_WIDTH-1];
          setup_cnt_n = '0;
          state_n     = S_SETUP;
        end
      end

      S_SETUP: begin
        if (setup_cnt == SETUP_LAST) begin
          ready_n    = 1'b1;
          tout_cnt_n = '0;
          state_n    = S_WAIT_HI;
        end else begin
          setup_cnt_n = setup_cnt + SW'(1);
        end
      end

      S_WAIT_HI: begin
        if (ack_s) begin
          ready_n    = 1'b0;
          tout_cnt_n = '0;
          state_n    = S_WAIT_LO;
        end else if (tout_last) begin
          ready_n = 1'b0;
          bit_n   = 1'b0;
          busy_n  = 1'b0;
          terr_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          tout_cnt_n = tout_cnt + TW'(1);
        end
      end

      S_WAIT_LO: begin
        ready_n = 1'b0;
        if (!ack_s) begin
          if (idx == '0) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            // Rotating keeps every shift bit in use; the next bit always sits at [MSB-1].
            idx_n       = idx - IW'(1);
            shift_n     = {shift[WORD_WIDTH-2:0], shift[WORD_WIDTH-1]};
            bit_n       = shift[WORD_WIDTH-2];
            setup_cnt_n = '0;
            state_n     = S_SETUP;
          end
        end else if (tout_last) begin
          bit_n   = 1'b0;
          busy_n  = 1'b0;
          terr_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          tout_cnt_n = tout_cnt + TW'(1);
        end
      end
    endcase
  end

  assign bus.tx_ready    = ready_q;
  assign bus.tx_bit      = bit_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;
  assign bus.tx_state    = state;

endmodule

// File: tb/tb_status_transmitter.sv
// Bench for status_transmitter: timestamp-based reference model checked every cycle,
// directed handshake scenarios with literal timing checks, then randomized traffic.
module tb_status_transmitter;

  localparam int WW    = 10;
  localparam int SETUP = 4;
  localparam int TOUT  = 50;

  localparam int M_SILENT = 0;
  localparam int M_ECHO   = 1;
  localparam int M_STUCK  = 2;
  localparam int M_HOLD   = 3;
  localparam int M_RANDOM = 4;

  localparam int P_IDLE = 0;
  localparam int P_SETUP = 1;
  localparam int P_HI = 2;
  localparam int P_LO = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  status_transmitter_if #(.WORD_WIDTH(WW)) bus ();

  status_transmitter #(
    .WORD_WIDTH  (WW),
    .SETUP_CYCLES(SETUP),
    .ACK_TIMEOUT (TOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int fails = 0;
  int cyc = 0;
  int mbed_mode = M_SILENT;
  int got_q[$];

  // Reference model: outputs expected after each rising edge, derived from phase entry times.
  bit          ack_hist[8];
  bit          rst_hist[8];
  int          m_phase = P_IDLE;
  int          m_t0 = 0;
  int          m_idx = 0;
  logic [WW-1:0] m_word = '0;
  bit          m_ready = 0, m_bit = 0, m_busy = 0, m_done = 0, m_terr = 0;

  initial begin : model
    bit ack_seen;
    forever begin
      @(posedge clk);
      cyc++;
      ack_hist[cyc % 8] = bus.tx_ack;
      rst_hist[cyc % 8] = reset;
      // ack reaches the decision logic two edges after it was sampled, unless reset cleared the path
      ack_seen = (cyc >= 2) && !rst_hist[(cyc - 1) % 8] && !rst_hist[(cyc - 2) % 8]
                 && ack_hist[(cyc - 2) % 8];
      m_done = 0;
      m_terr = 0;
      if (reset) begin
        m_phase = P_IDLE; m_ready = 0; m_bit = 0; m_busy = 0;
      end else begin
        case (m_phase)
          P_IDLE: if (bus.load) begin
            m_word = bus.word; m_idx = WW - 1; m_busy = 1;
            m_bit = m_word[m_idx]; m_phase = P_SETUP; m_t0 = cyc;
          end
          P_SETUP: if (cyc - m_t0 == SETUP) begin
            m_ready = 1; m_phase = P_HI; m_t0 = cyc;
          end
          P_HI: if (ack_seen) begin
            m_ready = 0; m_phase = P_LO; m_t0 = cyc;
          end else if (cyc - m_t0 == TOUT) begin
            m_ready = 0; m_bit = 0; m_busy = 0; m_terr = 1; m_phase = P_IDLE;
          end
          default: if (!ack_seen) begin
            if (m_idx == 0) begin
              m_done = 1; m_busy = 0; m_phase = P_IDLE;
            end else begin
              m_idx--; m_bit = m_word[m_idx]; m_phase = P_SETUP; m_t0 = cyc;
            end
          end else if (cyc - m_t0 == TOUT) begin
            m_ready = 0; m_bit = 0; m_busy = 0; m_terr = 1; m_phase = P_IDLE;
          end
        endcase
      end
    end
  end

  initial begin : compare
    logic [6:0] got_v, exp_v;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        got_v = {bus.tx_ready, bus.tx_bit, bus.busy, bus.done, bus.timeout_err, bus.tx_state};
        exp_v = {m_ready, m_bit, m_busy, m_done, m_terr, 2'(m_phase)};
        n_vec++;
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL cycle_compare @%0d: got rdy/bit/busy/done/terr/state=%b expected %b",
                   cyc, got_v, exp_v);
        end
      end
    end
  end

  // MBED stand-in; drives ack away from the sampling edge.
  initial begin : mbed
    forever begin
      @(negedge clk);
      case (mbed_mode)
        M_ECHO:   bus.tx_ack = bus.tx_ready;
        M_STUCK:  bus.tx_ack = bus.tx_ack | bus.tx_ready;
        M_HOLD:   bus.tx_ack = 1'b1;
        M_RANDOM: if (bus.tx_ack != bus.tx_ready && $urandom_range(0, 2) == 0)
                    bus.tx_ack = bus.tx_ready;
        default:  bus.tx_ack = 1'b0;
      endcase
    end
  end

  // Reassembles words from the bits present at each tx_ready rise.
  initial begin : collector
    int cur, prev_ready;
    cur = 0; prev_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.tx_ready === 1'b1 && prev_ready == 0) cur = ((cur << 1) | int'(bus.tx_bit)) & 10'h3FF;
      prev_ready = (bus.tx_ready === 1'b1) ? 1 : 0;
      if (bus.done === 1'b1) begin
        got_q.push_back(cur); cur = 0;
      end else if (bus.busy !== 1'b1) begin
        cur = 0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_load(input logic [WW-1:0] w, output int k);
    bus.load = 1'b1;
    bus.word = w;
    k = cyc + 1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic wait_ready(input string name, input bit level, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.tx_ready === level) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) check({name, "_wait"}, 0, 1);
  endtask

  task automatic run_until_end(input string name, input int budget, output int busy_cyc,
                               output int end_cyc, output int got_done, output int got_terr);
    busy_cyc = 0; end_cyc = -1; got_done = 0; got_terr = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done === 1'b1 || bus.timeout_err === 1'b1) begin
        got_done = (bus.done === 1'b1) ? 1 : 0;
        got_terr = (bus.timeout_err === 1'b1) ? 1 : 0;
        end_cyc = cyc;
        break;
      end
      if (bus.busy === 1'b1) busy_cyc++;
      tick();
    end
    if (end_cyc < 0) check({name, "_end_wait"}, 0, 1);
  endtask

  function automatic int pop_word();
    if (got_q.size() == 0) return -1;
    return got_q.pop_front();
  endfunction

  initial begin : main
    int k, k2, r, l, bc, ec, gd, gt, rises, pr;
    logic [WW-1:0] w;

    reset = 1'b1;
    bus.load = 1'b1;
    bus.word = 10'h3FF;
    bus.tx_ack = 1'b0;
    repeat (3) tick();
    check("reset_busy", int'(bus.busy), 0);
    check("reset_ready", int'(bus.tx_ready), 0);
    check("reset_state", int'(bus.tx_state), 0);
    reset = 1'b0;
    bus.load = 1'b0;
    tick();
    check("reset_no_start", int'(bus.busy), 0);

    // Ideal MBED, known word
    mbed_mode = M_ECHO;
    repeat (2) tick();
    send_load(10'b1011001110, k);
    run_until_end("normal", 300, bc, ec, gd, gt);
    check("normal_done", gd, 1);
    check("normal_latency", ec - k, 100);
    check("normal_busy_cycles", bc, 100);
    check("normal_word", pop_word(), 10'b1011001110);

    // Load while busy is dropped; load in the done cycle is taken
    repeat (4) tick();
    send_load(10'h2AA, k);
    repeat (29) tick();
    send_load(10'h155, k2);
    run_until_end("b2b_first", 300, bc, ec, gd, gt);
    check("b2b_first_done", gd, 1);
    check("b2b_first_latency", ec - k, 100);
    send_load(10'h155, k);
    check("b2b_no_gap", int'(bus.busy), 1);
    run_until_end("b2b_second", 300, bc, ec, gd, gt);
    check("b2b_second_latency", ec - k, 100);
    check("b2b_word0", pop_word(), 10'h2AA);
    check("b2b_word1", pop_word(), 10'h155);

    // MBED never acks
    repeat (4) tick();
    mbed_mode = M_SILENT;
    w = WW'($urandom);
    send_load(w, k);
    wait_ready("silent_rise", 1'b1, 20, r);
    check("silent_setup_len", r - k, SETUP);
    run_until_end("silent", 100, bc, ec, gd, gt);
    check("silent_terr", gt, 1);
    check("silent_no_done", gd, 0);
    check("silent_abort_time", ec - r, TOUT);

    // MBED acks but never releases
    repeat (4) tick();
    mbed_mode = M_STUCK;
    w = WW'($urandom);
    send_load(w, k);
    wait_ready("stuck_rise", 1'b1, 20, r);
    wait_ready("stuck_fall", 1'b0, 20, l);
    check("stuck_ack_response", l - r, 3);
    run_until_end("stuck", 100, bc, ec, gd, gt);
    check("stuck_terr", gt, 1);
    check("stuck_abort_time", ec - l, TOUT);
    mbed_mode = M_SILENT;
    repeat (5) tick();

    // Reset while waiting for ack on bit index 4, then a clean full word
    mbed_mode = M_ECHO;
    repeat (2) tick();
    w = WW'($urandom);
    send_load(w, k);
    rises = 0; pr = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.tx_ready === 1'b1 && pr == 0) rises++;
      pr = (bus.tx_ready === 1'b1) ? 1 : 0;
      if (rises == 6) break;
      tick();
    end
    check("rstmid_reached_bit4", rises, 6);
    check("rstmid_state", int'(bus.tx_state), P_HI);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_ready", int'(bus.tx_ready), 0);
    check("rstmid_busy", int'(bus.busy), 0);
    repeat (4) tick();
    w = WW'($urandom);
    send_load(w, k);
    run_until_end("rstmid_reload", 300, bc, ec, gd, gt);
    check("rstmid_reload_latency", ec - k, 100);
    check("rstmid_reload_word", pop_word(), int'(w));

    // ack already high at load, released 20 cycles after tx_ready rises
    mbed_mode = M_HOLD;
    repeat (4) tick();
    w = WW'($urandom);
    send_load(w, k);
    wait_ready("hold_rise", 1'b1, 20, r);
    repeat (20) tick();
    mbed_mode = M_ECHO;
    run_until_end("hold", 400, bc, ec, gd, gt);
    check("hold_done", gd, 1);
    check("hold_no_terr", gt, 0);
    check("hold_word", pop_word(), int'(w));

    // Randomized traffic with random ack delays and occasional resets
    mbed_mode = M_RANDOM;
    for (int i = 0; i < 1500; i++) begin
      bus.load = ($urandom_range(0, 9) == 0);
      bus.word = WW'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    bus.load = 1'b0;
    reset = 1'b0;
    mbed_mode = M_ECHO;
    repeat (150) tick();
    got_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, fails);
    $finish;
  end

endmodule

// File: doc/status_transmitter.md
# status_transmitter

Bit-serial transmitter that returns a 10-bit status word from the FPGA to the MBED. It uses the same four-phase ready/ack bit handshake that the MBED uses to deliver servo instructions, with the roles reversed: the FPGA drives ready and data, and the MBED drives ack. It sits beside the instruction receiver in the top level and reports state-machine state, trackswitch status and the current servo position. It has a per-bit acknowledge timeout, so a silent MBED cannot hang the FPGA.

## Interface
- WORD_WIDTH, 10: bits per transmitted word, sent MSB first.
- SETUP_CYCLES, 4: cycles that tx_bit is stable before tx_ready rises; must be ≥1.
- ACK_TIMEOUT, 24000000: cycles allowed in each ack-wait phase before abort (1 s at 24 MHz).
- clk  in  1  system clock (24 MHz).
- reset  in  1  synchronous, active-high reset.
- load  in  1  single-cycle request to send `word`; honoured only while busy=0.
- word  in  WORD_WIDTH  status word, captured on the accepted load edge.
- tx_ack  in  1  acknowledge from MBED; asynchronous, passed through a 2-flop synchronizer.
- tx_ready  out  1  bit-valid strobe to MBED.
- tx_bit  out  1  serial data line.
- busy  out  1  high from the accepted load until return to IDLE.
- done  out  1  one-cycle pulse when the last bit's handshake completes.
- timeout_err  out  1  one-cycle pulse when a transfer is aborted on timeout.
- tx_state  out  2  debug/LED: 0 IDLE, 1 SETUP, 2 WAIT_ACK_HI, 3 WAIT_ACK_LO.

## Operation
- All outputs are registered.
- Reset value of every output is 0. Reset also clears the shift register, bit index, both counters and the synchronizer flops. Reset overrides load in the same cycle.
- Reset mid-transfer aborts immediately: tx_ready goes 0 on the next edge, and neither done nor timeout_err fires.
- ack_s is the second synchronizer flop. Every decision on the ack line uses ack_s only, never tx_ack directly.
- **IDLE:** busy=0 and tx_ready=0.
  - On load=1: capture word into the shift register, set the bit index to WORD_WIDTH-1, set busy=1, set tx_bit=word[MSB], clear the setup counter and go to SETUP.
- **SETUP:** tx_ready stays 0 and tx_bit is held.
  - When setup count = SETUP_CYCLES-1: set tx_ready=1, clear the timeout counter and go to WAIT_ACK_HI.
- **WAIT_ACK_HI:** tx_ready and tx_bit are held.
  - If ack_s=1: set tx_ready=0, clear the timeout counter and go to WAIT_ACK_LO.
  - Else, if timeout count = ACK_TIMEOUT-1: abort.
- **WAIT_ACK_LO:** tx_ready=0.
  - If ack_s=0 and bit index=0: go to IDLE with done=1 and busy=0.
  - If ack_s=0 and bit index>0: decrement the index, shift, drive the next bit on tx_bit, clear the setup counter and go to SETUP.
  - Else, if timeout count = ACK_TIMEOUT-1: abort.
- **Abort:** go to IDLE with tx_ready=0, tx_bit=0, busy=0 and timeout_err=1. done is not asserted.
- load while busy=1 is ignored. It is not queued, and the word in flight is not disturbed.
- load in the same cycle that done or timeout_err is high is accepted, because the state is already IDLE.
- tx_ack already high when a transfer starts:
  - SETUP does not look at ack.
  - WAIT_ACK_HI sees it at once, so that bit completes only after the MBED drops ack.
  - This is legal protocol behaviour, not an error.
- Counter widths come from $clog2 of the parameters. Counters saturate and never wrap.
- tx_bit changes only on entry to SETUP or on abort/reset. It never changes while tx_ready=1.

## Timing
- Load accepted at edge k. tx_bit is valid and busy=1 from edge k.
- tx_ready rises at edge k+SETUP_CYCLES.
- Ack path: a tx_ack edge is visible in ack_s 2 cycles later. The FSM reacts on the following edge, so response time is 3 cycles from the tx_ack edge to the tx_ready or state change.
- With an ideal MBED that echoes tx_ready immediately, each bit takes SETUP_CYCLES + 6 cycles.
- A 10-bit word takes 10·(SETUP_CYCLES+6) cycles; with the defaults, 100 cycles from load to done.
- done and timeout_err are each exactly one cycle wide and never high together.
- The timeout counts the cycles spent in the current wait phase. Abort happens ACK_TIMEOUT cycles after entering that phase.

## Test plan
- **Reset values:** assert reset for 3 cycles with load=1 and word=10'h3FF → all outputs 0, tx_state=0, no transfer starts.
- **Normal transfer:** word=10'b1011001110, MBED model echoes tx_ready into tx_ack with 0-cycle delay → sampled bits 1,0,1,1,0,0,1,1,1,0 in order; tx_bit stable on every tx_ready rise; done pulses once at cycle 100 after load; busy high for exactly cycles 0–99.
- **Busy and back-to-back loads:** pulse load with 10'h155 mid-transfer of 10'h2AA → only 10'h2AA is sent. Pulse load in the done cycle → 10'h155 is sent next without an idle gap.
- **Timeout:** set ACK_TIMEOUT=50; MBED never acks → tx_ready falls and timeout_err pulses 50 cycles after tx_ready rose; no done. Repeat with the MBED raising ack but never lowering it → abort 50 cycles after WAIT_ACK_LO entry.
- **Reset mid-transfer:** assert reset in WAIT_ACK_HI of bit 4 → tx_ready=0 and busy=0 on the next edge. A new load then sends its full word from the MSB.
- **Slow/stuck-high ack:** tx_ack held high before load, released 20 cycles after tx_ready rises → bit 9 completes after the release, with no protocol error.
